// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Purpose:
//   Shares the single register-file write port among NREQ writeback sources
//   (ALU, load unit, mul/div HI/LO path). It can also run a clear sweep that
//   writes 0 to registers 1..31 on request. The block sits between the
//   writeback sources and the reg32 array's write decoder. The write-port
//   outputs are registered and drive the register file directly.
//
// Build option:
//   REGARB_RR_EN  defined   -> round-robin arbitration starting at rr_ptr
//                 undefined -> fixed priority, requester 0 highest
//   The FSM, the clear sweep and the handshake are the same in both builds.
//
// Handshake:
//   A requester raises req_valid[i] and holds req_addr/req_data stable until
//   it sees req_ready[i]. The transfer happens on the rising edge where
//   valid & ready are both high. req_ready is combinational and at most
//   one-hot. No grant is given while rf_hold=1, in a clear_start cycle, or
//   during a sweep.
//
// Ports:
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   req_valid    in   NREQ     requester i has a pending write
//   req_addr     in   NREQ*AW  dest reg of requester i, bits [AW*i +: AW]
//   req_data     in   NREQ*DW  write data of requester i, bits [DW*i +: DW]
//   req_ready    out  NREQ     one-hot grant
//   rf_hold      in   1        freeze: no grants, no writes, sweep pauses
//   clear_start  in   1        pulse: start the clear sweep
//   clear_busy   out  1        sweep in progress
//   rf_wen       out  1        register-file write enable (registered)
//   rf_waddr     out  AW       register-file write address (registered)
//   rf_wdata     out  DW       register-file write data (registered)
//   fsm_state    out  1        debug view of the FSM: 0 = S_ARB, 1 = S_CLEAR
// ---------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rf_hold,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic                 fsm_state
);

    typedef enum logic {
        S_ARB   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // The sweep covers the architectural registers 1..31.
    localparam logic [AW-1:0] LAST_REG = AW'(31);

    state_t          state, state_next;
    logic [AW-1:0]   clr_cnt, clr_cnt_next;
    logic            wen_next;
    logic [AW-1:0]   waddr_next;
    logic [DW-1:0]   wdata_next;

    logic            grant_en;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Grants only happen in S_ARB, outside hold, and never in a cycle that
    // starts a sweep (a hold-masked clear_start does not block grants, since
    // rf_hold already does).
    assign grant_en = (state == S_ARB) && !rf_hold && !clear_start;

`ifdef REGARB_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr, rr_next;
    logic [NREQ-1:0] rot;
    logic [PW:0]     pos;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, pick the
    // first set bit, then map its offset back to an absolute index.
    always_comb begin
        cand = '0;
        pos  = '0;
        rot  = NREQ'({req_valid, req_valid} >> rr_ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (rot[k] && (cand == '0)) begin
                pos = {1'b0, rr_ptr} + (PW+1)'(k);
                if (pos >= (PW+1)'(NREQ))
                    pos = pos - (PW+1)'(NREQ);
                cand[pos[PW-1:0]] = 1'b1;
            end
        end
    end

    // Pointer moves past the granted requester, including addr-0 discards.
    always_comb begin
        rr_next = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k])
                rr_next = (k == NREQ - 1) ? '0 : PW'(k + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (|grant)
            rr_ptr <= rr_next;
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && (cand == '0))
                cand[k] = 1'b1;
        end
    end
`endif

    assign grant     = grant_en ? cand : '0;
    assign req_ready = grant;

    // Mux the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_addr = req_addr[k*AW +: AW];
                sel_data = req_data[k*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        wen_next     = 1'b0;
        waddr_next   = rf_waddr;
        wdata_next   = rf_wdata;
        case (state)
            S_ARB: begin
                if (clear_start && !rf_hold) begin
                    state_next   = S_CLEAR;
                    clr_cnt_next = AW'(1);
                end else if ((|grant) && (sel_addr != '0)) begin
                    // A write to $zero is accepted but never reaches the file.
                    wen_next   = 1'b1;
                    waddr_next = sel_addr;
                    wdata_next = sel_data;
                end
            end
            S_CLEAR: begin
                if (!rf_hold) begin
                    wen_next   = 1'b1;
                    waddr_next = clr_cnt;
                    wdata_next = '0;
                    if (clr_cnt == LAST_REG) begin
                        state_next   = S_ARB;
                        clr_cnt_next = '0;
                    end else begin
                        clr_cnt_next = clr_cnt + AW'(1);
                    end
                end
            end
            default: begin
                state_next   = S_ARB;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_ARB;
            clr_cnt  <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_next;
            clr_cnt  <= clr_cnt_next;
            rf_wen   <= wen_next;
            rf_waddr <= waddr_next;
            rf_wdata <= wdata_next;
        end
    end

    assign clear_busy = (state == S_CLEAR);
    assign fsm_state  = (state == S_CLEAR);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wport_arbiter
//
// Directed bench for rf_wport_arbiter (NREQ=3, AW=5, DW=32). Inputs are
// driven 1 time unit after each rising edge; outputs are checked 1 time unit
// later, so a registered output seen in cycle N reflects the decision made
// in cycle N-1. Expectations that differ between the fixed-priority and
// round-robin builds follow REGARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_rf_wport_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rf_hold;
    logic                clear_start;
    logic                clear_busy;
    logic                rf_wen;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                fsm_state;

    int n_cmp;
    int n_err;

    logic [AW-1:0] exp_q[$];

    rf_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_hold     (rf_hold),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[idx*AW +: AW] = a;
        req_data[idx*DW +: DW] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [AW-1:0] exp_a;
        int            g;
        int            prev_g;
        logic          exp_wen;

        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        rf_hold     = 1'b0;
        clear_start = 1'b0;
        g           = 0;
        prev_g      = 0;

        // ---- 1: reset state ----
        repeat (3) tick();
        reset = 1'b0;
        settle();
        chk("rst_wen",   32'(rf_wen),     32'd0);
        chk("rst_ready", 32'(req_ready),  32'd0);
        chk("rst_busy",  32'(clear_busy), 32'd0);
        chk("rst_waddr", 32'(rf_waddr),   32'd0);
        chk("rst_wdata", rf_wdata,        32'd0);
        chk("rst_state", 32'(fsm_state),  32'd0);

        // ---- 2: single requester 1 ----
        tick();
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'h1234ABCD);
        settle();
        chk("t2_ready",  32'(req_ready), 32'b010);
        chk("t2_wen_n",  32'(rf_wen),    32'd0);
        tick();
        req_valid = '0;
        settle();
        chk("t2_wen",    32'(rf_wen),    32'd1);
        chk("t2_waddr",  32'(rf_waddr),  32'd5);
        chk("t2_wdata",  rf_wdata,       32'h1234ABCD);
        chk("t2_ready0", 32'(req_ready), 32'd0);
        tick();
        settle();
        chk("t2_wen_off", 32'(rf_wen),   32'd0);
        chk("t2_hold_a",  32'(rf_waddr), 32'd5);

        // Fresh pointer for the arbitration pattern.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---- 3: all three valid for 6 cycles ----
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h000000A0);
        set_req(1, 5'd2, 32'h000000A1);
        set_req(2, 5'd3, 32'h000000A2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            settle();
`ifdef REGARB_RR_EN
            g = i % 3;
`else
            g = 0;
`endif
            chk($sformatf("t3_ready_%0d", i), 32'(req_ready), 32'(1 << g));
            if (i > 0) begin
                chk($sformatf("t3_wen_%0d", i),   32'(rf_wen),   32'd1);
                chk($sformatf("t3_waddr_%0d", i), 32'(rf_waddr), 32'(prev_g + 1));
                chk($sformatf("t3_wdata_%0d", i), rf_wdata,      32'(32'hA0 + prev_g));
            end
            prev_g = g;
        end
        tick();
        req_valid = '0;
        settle();
        chk("t3_wen_last",   32'(rf_wen),   32'd1);
        chk("t3_waddr_last", 32'(rf_waddr), 32'(prev_g + 1));
        chk("t3_ready_idle", 32'(req_ready), 32'd0);
        tick();
        settle();
        chk("t3_wen_off", 32'(rf_wen), 32'd0);

        // ---- 4: write to $zero is accepted but discarded ----
        tick();
        req_valid = 3'b011;
        set_req(0, 5'd0, 32'hFFFFFFFF);
        set_req(1, 5'd7, 32'h00000077);
        settle();
        chk("t4_ready0", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b010;
        settle();
        chk("t4_ready1", 32'(req_ready), 32'b010);
        chk("t4_wen0",   32'(rf_wen),    32'd0);
        chk("t4_waddr_hold", 32'(rf_waddr), 32'(prev_g + 1));
        chk("t4_wdata_hold", rf_wdata,      32'(32'hA0 + prev_g));
        tick();
        req_valid = '0;
        settle();
        chk("t4_wen1",   32'(rf_wen),   32'd1);
        chk("t4_waddr",  32'(rf_waddr), 32'd7);
        chk("t4_wdata",  rf_wdata,      32'h00000077);

        // ---- hold blocks grants; clear_start under hold is ignored ----
        tick();
        rf_hold   = 1'b1;
        req_valid = 3'b001;
        set_req(0, 5'd9, 32'h00000099);
        settle();
        chk("hold_ready", 32'(req_ready), 32'd0);
        chk("hold_wen",   32'(rf_wen),    32'd0);
        tick();
        clear_start = 1'b1;
        settle();
        chk("hold_clr_ready", 32'(req_ready), 32'd0);
        tick();
        clear_start = 1'b0;
        rf_hold     = 1'b0;
        settle();
        chk("hold_clr_busy", 32'(clear_busy), 32'd0);
        chk("hold_clr_wen",  32'(rf_wen),     32'd0);
        chk("unhold_ready",  32'(req_ready),  32'b001);
        tick();
        req_valid = '0;
        settle();
        chk("unhold_wen",   32'(rf_wen),   32'd1);
        chk("unhold_waddr", 32'(rf_waddr), 32'd9);
        tick();

        // ---- 5: clear sweep with hold at C+5..C+6 ----
        for (int a = 1; a <= 31; a++) exp_q.push_back(AW'(a));
        for (int t = 0; t <= 35; t++) begin
            tick();
            clear_start = (t == 0);
            rf_hold     = (t == 5) || (t == 6);
            req_valid   = (t <= 33) ? 3'b111 : 3'b000;
            settle();
            exp_wen = ((t >= 2) && (t <= 5)) || ((t >= 8) && (t <= 34));
            chk($sformatf("t5_ready_%0d", t), 32'(req_ready),  32'd0);
            chk($sformatf("t5_busy_%0d", t),  32'(clear_busy), 32'((t >= 1) && (t <= 33)));
            chk($sformatf("t5_wen_%0d", t),   32'(rf_wen),     32'(exp_wen));
            if (rf_wen) begin
                if (exp_q.size() > 0) begin
                    exp_a = exp_q.pop_front();
                    chk($sformatf("t5_waddr_%0d", t), 32'(rf_waddr), 32'(exp_a));
                end else begin
                    chk($sformatf("t5_extra_write_%0d", t), 32'(rf_waddr), 32'hFFFFFFFF);
                end
                chk($sformatf("t5_wdata_%0d", t), rf_wdata, 32'd0);
            end
        end
        chk("t5_all_written", 32'(exp_q.size()), 32'd0);
        clear_start = 1'b0;
        rf_hold     = 1'b0;

        // ---- 6: reset mid-sweep at clr_cnt=10 ----
        tick();
        clear_start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            clear_start = 1'b0;
        end
        tick();
        reset = 1'b1;
        settle();
        chk("t6_pre_wen",   32'(rf_wen),     32'd1);
        chk("t6_pre_waddr", 32'(rf_waddr),   32'd9);
        chk("t6_pre_busy",  32'(clear_busy), 32'd1);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_wen",   32'(rf_wen),     32'd0);
        chk("t6_busy",  32'(clear_busy), 32'd0);
        chk("t6_state", 32'(fsm_state),  32'd0);
        chk("t6_waddr", 32'(rf_waddr),   32'd0);
        tick();
        settle();
        chk("t6_wen_after", 32'(rf_wen), 32'd0);
        tick();
        req_valid = 3'b100;
        set_req(2, 5'd12, 32'hCAFEF00D);
        settle();
        chk("t6_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        settle();
        chk("t6_req_wen",   32'(rf_wen),   32'd1);
        chk("t6_req_waddr", 32'(rf_waddr), 32'd12);
        chk("t6_req_wdata", rf_wdata,      32'hCAFEF00D);

        // ---- report ----
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
